// File: rtl/riscv_pkg.sv
// Shared RV32I constants and the fetch-stage entry type.
// Imported by the fetch interface, the fetch unit and its buffer.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [6:0]      OPC_OP     = 7'b0110011;
    localparam logic [6:0]      OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]      OPC_LUI    = 7'b0110111;
    localparam logic [ILEN-1:0] NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
// master = fetch unit side, slave = memory/decode/branch-unit side.
interface fetch_unit_if;

    logic                      imem_req_valid;
    logic                      imem_req_ready;
    logic [riscv_pkg::XLEN-1:0] imem_req_addr;
    logic                      imem_rsp_valid;
    logic [riscv_pkg::ILEN-1:0] imem_rsp_data;
    logic                      redirect_valid;
    logic [riscv_pkg::XLEN-1:0] redirect_pc;
    logic                      inst_valid;
    logic                      inst_ready;
    logic [riscv_pkg::ILEN-1:0] inst_data;
    logic [riscv_pkg::XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally and
// forced to zero while empty so stale storage never leaks out.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset: the head is masked whenever the FIFO is empty.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        assign mem_d[gi] = (do_push && (wptr_q == AW'(gi))) ? push_data : mem_q[gi];
        always_ff @(posedge clk) begin
            mem_q[gi] <= mem_d[gi];
        end
    end

    assign head_data = empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, credit-limited memory requests, response buffer
// and redirect/flush with dropping of in-flight responses.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   out_next;
    logic [CW:0]     credit_used;

    logic            accept, pop, rsp, live_rsp, redirect;
    fetch_entry_t    push_entry, head_entry;
    logic [CW-1:0]   data_count, tag_count;
    logic            data_full, data_empty, tag_full, tag_empty;
    logic [XLEN-1:0] tag_head;

    assign redirect = bus.redirect_valid;
    assign accept   = bus.imem_req_valid && bus.imem_req_ready;
    assign pop      = bus.inst_valid && bus.inst_ready;
    assign rsp      = bus.imem_rsp_valid;
    assign live_rsp = rsp && (drop_q == '0) && !redirect;

    // A pop on this edge frees its slot in time for any response to a new request.
    assign credit_used = {1'b0, out_q} + {1'b0, data_count} - (CW+1)'(pop);

    assign bus.imem_req_valid = rst_n && !redirect && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign bus.imem_req_addr  = pc_q;

    assign out_next = out_q + CW'(accept) - CW'(rsp);

    always_comb begin
        pc_d   = pc_q;
        out_d  = out_next;
        drop_d = drop_q;
        if (accept) pc_d = pc_q + 32'd4;
        if (redirect) begin
            pc_d   = word_align(bus.redirect_pc);
            drop_d = out_next;
        end else if (rsp && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    assign push_entry = '{inst: bus.imem_rsp_data, pc: tag_head};

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (accept),
        .push_data (pc_q),
        .pop       (live_rsp),
        .head_data (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    fetch_fifo #(.WIDTH(ILEN + XLEN), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (live_rsp),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (data_count),
        .full      (data_full),
        .empty     (data_empty)
    );

    assign bus.inst_valid = !data_empty;
    assign bus.inst_data  = head_entry.inst;
    assign bus.inst_pc    = head_entry.pc;

    // Invariants of the credit scheme: every live response has a tag and a slot.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (drop_q <= out_q);
            assert (tag_count == out_q - drop_q);
            assert (!(live_rsp && tag_empty));
            assert (!(live_rsp && data_full && !pop));
            assert (!(accept && tag_full));
        end
    end

endmodule
